// File: rtl/vga_timing_pkg.sv
// Shared 1280x1024@60 raster constants, microphone mid-code and the magnitude helper.
// Imported by the frame source, the sync counter and the circle renderer.
package vga_timing_pkg;

    localparam int H_ACTIVE     = 1280;
    localparam int H_FP         = 48;
    localparam int H_SYNC       = 112;
    localparam int H_BP         = 248;
    localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;

    localparam int V_ACTIVE     = 1024;
    localparam int V_FP         = 1;
    localparam int V_SYNC       = 3;
    localparam int V_BP         = 38;
    localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam int COORD_W  = 12;
    localparam int MIC_W    = 12;
    localparam int SAMPLE_W = 21;

    localparam logic [MIC_W-1:0] MIC_MID = 12'd2048;

    // Distance of an unsigned ADC code from the zero-signal code, 0..2048.
    function automatic logic [MIC_W-1:0] mic_magnitude(input logic [MIC_W-1:0] code);
        if (code >= MIC_MID) begin
            return code - MIC_MID;
        end else begin
            return MIC_MID - code;
        end
    endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Raster position counters with hsync/vsync/active/frame_start registered from the
// next position, so every flag describes the horz/vert value presented alongside it.
module vga_sync_counter
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE_CFG = H_ACTIVE,
    parameter int H_FP_CFG     = H_FP,
    parameter int H_SYNC_CFG   = H_SYNC,
    parameter int H_BP_CFG     = H_BP,
    parameter int V_ACTIVE_CFG = V_ACTIVE,
    parameter int V_FP_CFG     = V_FP,
    parameter int V_SYNC_CFG   = V_SYNC,
    parameter int V_BP_CFG     = V_BP
) (
    input  logic                clk,
    input  logic                reset,
    output logic [COORD_W-1:0]  horz,
    output logic [COORD_W-1:0]  vert,
    output logic                hsync,
    output logic                vsync,
    output logic                active,
    output logic                frame_start
);

    localparam logic [COORD_W-1:0] H_LAST = 12'(H_ACTIVE_CFG + H_FP_CFG + H_SYNC_CFG + H_BP_CFG - 1);
    localparam logic [COORD_W-1:0] V_LAST = 12'(V_ACTIVE_CFG + V_FP_CFG + V_SYNC_CFG + V_BP_CFG - 1);
    localparam logic [COORD_W-1:0] H_VIS  = 12'(H_ACTIVE_CFG);
    localparam logic [COORD_W-1:0] V_VIS  = 12'(V_ACTIVE_CFG);
    localparam logic [COORD_W-1:0] HS_LO  = 12'(H_ACTIVE_CFG + H_FP_CFG);
    localparam logic [COORD_W-1:0] HS_HI  = 12'(H_ACTIVE_CFG + H_FP_CFG + H_SYNC_CFG);
    localparam logic [COORD_W-1:0] VS_LO  = 12'(V_ACTIVE_CFG + V_FP_CFG);
    localparam logic [COORD_W-1:0] VS_HI  = 12'(V_ACTIVE_CFG + V_FP_CFG + V_SYNC_CFG);

    logic [COORD_W-1:0] horz_r;
    logic [COORD_W-1:0] vert_r;
    logic [COORD_W-1:0] horz_nxt_s;
    logic [COORD_W-1:0] vert_nxt_s;
    logic               hsync_r;
    logic               vsync_r;
    logic               active_r;
    logic               frame_start_r;

    // Next raster position: vert advances (and wraps) only when horz wraps.
    always_comb begin
        horz_nxt_s = horz_r;
        vert_nxt_s = vert_r;
        if (horz_r == H_LAST) begin
            horz_nxt_s = 12'd0;
            if (vert_r == V_LAST) begin
                vert_nxt_s = 12'd0;
            end else begin
                vert_nxt_s = vert_r + 12'd1;
            end
        end else begin
            horz_nxt_s = horz_r + 12'd1;
        end
    end

    // Position and flag registers; flags decode the next position to stay aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            horz_r        <= H_LAST;
            vert_r        <= V_LAST;
            hsync_r       <= 1'b0;
            vsync_r       <= 1'b0;
            active_r      <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            horz_r        <= horz_nxt_s;
            vert_r        <= vert_nxt_s;
            hsync_r       <= (horz_nxt_s >= HS_LO) && (horz_nxt_s < HS_HI);
            vsync_r       <= (vert_nxt_s >= VS_LO) && (vert_nxt_s < VS_HI);
            active_r      <= (horz_nxt_s < H_VIS) && (vert_nxt_s < V_VIS);
            frame_start_r <= (horz_nxt_s == 12'd0) && (vert_nxt_s == 12'd0);
        end
    end

    assign horz        = horz_r;
    assign vert        = vert_r;
    assign hsync       = hsync_r;
    assign vsync       = vsync_r;
    assign active      = active_r;
    assign frame_start = frame_start_r;

endmodule

// File: rtl/vga_frame_source.sv
// Raster timing plus a frame-stable microphone amplitude published at each frame start.
// Build option VGA_PEAK_HOLD_EN: publish the frame peak instead of the latest magnitude.
module vga_frame_source
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE_CFG = H_ACTIVE,
    parameter int H_FP_CFG     = H_FP,
    parameter int H_SYNC_CFG   = H_SYNC,
    parameter int H_BP_CFG     = H_BP,
    parameter int V_ACTIVE_CFG = V_ACTIVE,
    parameter int V_FP_CFG     = V_FP,
    parameter int V_SYNC_CFG   = V_SYNC,
    parameter int V_BP_CFG     = V_BP
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [MIC_W-1:0]     mic_sample,
    input  logic                 mic_valid,
    output logic [COORD_W-1:0]   horz,
    output logic [COORD_W-1:0]   vert,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 active,
    output logic                 frame_start,
    output logic [SAMPLE_W-1:0]  sample
);

    localparam logic [COORD_W-1:0] H_LAST = 12'(H_ACTIVE_CFG + H_FP_CFG + H_SYNC_CFG + H_BP_CFG - 1);
    localparam logic [COORD_W-1:0] V_LAST = 12'(V_ACTIVE_CFG + V_FP_CFG + V_SYNC_CFG + V_BP_CFG - 1);

    logic [MIC_W-1:0]    mag_s;
    logic                boundary_s;
    logic [MIC_W-1:0]    held_r;
    logic [MIC_W-1:0]    held_nxt_s;
    logic [SAMPLE_W-1:0] sample_r;

    vga_sync_counter #(
        .H_ACTIVE_CFG (H_ACTIVE_CFG),
        .H_FP_CFG     (H_FP_CFG),
        .H_SYNC_CFG   (H_SYNC_CFG),
        .H_BP_CFG     (H_BP_CFG),
        .V_ACTIVE_CFG (V_ACTIVE_CFG),
        .V_FP_CFG     (V_FP_CFG),
        .V_SYNC_CFG   (V_SYNC_CFG),
        .V_BP_CFG     (V_BP_CFG)
    ) u_sync (
        .clk         (clk),
        .reset       (reset),
        .horz        (horz),
        .vert        (vert),
        .hsync       (hsync),
        .vsync       (vsync),
        .active      (active),
        .frame_start (frame_start)
    );

    assign mag_s = mic_magnitude(mic_sample);

    // The edge leaving the last pixel of the frame is the one that lands on (0,0).
    assign boundary_s = (horz == H_LAST) && (vert == V_LAST);

    // Hold update; a sample arriving on the boundary edge is counted in the new frame.
    always_comb begin
        held_nxt_s = held_r;
`ifdef VGA_PEAK_HOLD_EN
        if (boundary_s) begin
            if (mic_valid) begin
                held_nxt_s = mag_s;
            end else begin
                held_nxt_s = 12'd0;
            end
        end else if (mic_valid && (mag_s > held_r)) begin
            held_nxt_s = mag_s;
        end else begin
            held_nxt_s = held_r;
        end
`else
        if (mic_valid) begin
            held_nxt_s = mag_s;
        end else begin
            held_nxt_s = held_r;
        end
`endif
    end

    // Hold register and the published amplitude, which only changes at frame start.
    always_ff @(posedge clk) begin
        if (reset) begin
            held_r   <= 12'd0;
            sample_r <= 21'd0;
        end else begin
            held_r <= held_nxt_s;
            if (boundary_s) begin
                sample_r <= {9'd0, held_r};
            end else begin
                sample_r <= sample_r;
            end
        end
    end

    assign sample = sample_r;

endmodule

// File: tb/tb_vga_frame_source.sv
// Bench: a reduced-raster instance carries the frame-level scenarios, a full-size instance
// carries the 1280x1024 line timing; both are checked every cycle against an arithmetic model.
module tb_vga_frame_source;

    localparam int SHA = 16, SHF = 2, SHS = 3, SHB = 4;
    localparam int SVA = 10, SVF = 1, SVS = 2, SVB = 3;
    localparam int S_HT = SHA + SHF + SHS + SHB;
    localparam int S_VT = SVA + SVF + SVS + SVB;
    localparam int F_S  = S_HT * S_VT;
    localparam int FHA = 1280, FHF = 48, FHS = 112, FHB = 248;
    localparam int FVA = 1024, FVF = 1, FVS = 3, FVB = 38;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] mic_sample = 12'd2048;
    logic        mic_valid = 1'b0;

    logic [11:0] s_horz, s_vert, f_horz, f_vert;
    logic        s_hsync, s_vsync, s_active, s_fs;
    logic        f_hsync, f_vsync, f_active, f_fs;
    logic [20:0] s_sample, f_sample;

    int checks = 0;
    int errors = 0;
    int t = -1;
    int q[$];
    int last_seen = 0;
    int pub = 0;

    typedef struct {
        int n;
        int s0;
        int s1;
        int s2;
        int exp_peak;
        int exp_last;
    } row_t;
    row_t rows[6];

    typedef struct {
        int h;
        int v;
        int hs;
        int vs;
        int act;
        int fs;
    } tim_t;

    always #5 clk = ~clk;

    vga_frame_source #(
        .H_ACTIVE_CFG(SHA), .H_FP_CFG(SHF), .H_SYNC_CFG(SHS), .H_BP_CFG(SHB),
        .V_ACTIVE_CFG(SVA), .V_FP_CFG(SVF), .V_SYNC_CFG(SVS), .V_BP_CFG(SVB)
    ) dut (
        .clk(clk), .reset(reset), .mic_sample(mic_sample), .mic_valid(mic_valid),
        .horz(s_horz), .vert(s_vert), .hsync(s_hsync), .vsync(s_vsync),
        .active(s_active), .frame_start(s_fs), .sample(s_sample)
    );

    vga_frame_source dut_full (
        .clk(clk), .reset(reset), .mic_sample(mic_sample), .mic_valid(mic_valid),
        .horz(f_horz), .vert(f_vert), .hsync(f_hsync), .vsync(f_vsync),
        .active(f_active), .frame_start(f_fs), .sample(f_sample)
    );

    function automatic int mag(input int code);
        return (code >= 2048) ? code - 2048 : 2048 - code;
    endfunction

    function automatic int row_exp(input row_t r);
`ifdef VGA_PEAK_HOLD_EN
        return r.exp_peak;
`else
        return r.exp_last;
`endif
    endfunction

    function automatic tim_t timing(input int tt, input int ha, input int hf, input int hs,
                                    input int hb, input int va, input int vf, input int vs,
                                    input int vb);
        tim_t e;
        int ht, vt;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        if (tt < 0) begin
            e = '{h: ht - 1, v: vt - 1, hs: 0, vs: 0, act: 0, fs: 0};
        end else begin
            e.h   = tt % ht;
            e.v   = (tt / ht) % vt;
            e.hs  = (e.h >= ha + hf && e.h < ha + hf + hs) ? 1 : 0;
            e.vs  = (e.v >= va + vf && e.v < va + vf + vs) ? 1 : 0;
            e.act = (e.h < ha && e.v < va) ? 1 : 0;
            e.fs  = (e.h == 0 && e.v == 0) ? 1 : 0;
        end
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0d)", name, act, exp, t);
        end
    endtask

    task automatic check_all();
        tim_t es, ef;
        es = timing(t, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB);
        ef = timing(t, FHA, FHF, FHS, FHB, FVA, FVF, FVS, FVB);
        chk("s_horz", int'(s_horz), es.h);
        chk("s_vert", int'(s_vert), es.v);
        chk("s_hsync", int'(s_hsync), es.hs);
        chk("s_vsync", int'(s_vsync), es.vs);
        chk("s_active", int'(s_active), es.act);
        chk("s_frame_start", int'(s_fs), es.fs);
        chk("s_sample", int'(s_sample), pub);
        chk("f_horz", int'(f_horz), ef.h);
        chk("f_vert", int'(f_vert), ef.v);
        chk("f_hsync", int'(f_hsync), ef.hs);
        chk("f_vsync", int'(f_vsync), ef.vs);
        chk("f_active", int'(f_active), ef.act);
        chk("f_frame_start", int'(f_fs), ef.fs);
        chk("f_sample", int'(f_sample), 0);
    endtask

    // One clock: drive, advance the model on the edge, compare on the falling edge.
    task automatic step(input logic rst, input logic v, input int d);
        reset      = rst;
        mic_valid  = v;
        mic_sample = 12'(d);
        @(posedge clk);
        if (rst) begin
            t = -1;
            q.delete();
            last_seen = 0;
            pub = 0;
        end else begin
            t = t + 1;
            if (t % F_S == 0) begin
`ifdef VGA_PEAK_HOLD_EN
                pub = 0;
                foreach (q[i]) if (q[i] > pub) pub = q[i];
`else
                pub = last_seen;
`endif
                q.delete();
            end
            if (v) begin
                q.push_back(mag(d));
                last_seen = mag(d);
            end
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int fs_count;
        rows[0] = '{n: 3, s0: 2100, s1: 1500, s2: 2048, exp_peak: 548,  exp_last: 0};
        rows[1] = '{n: 0, s0: 0,    s1: 0,    s2: 0,    exp_peak: 0,    exp_last: 0};
        rows[2] = '{n: 1, s0: 4095, s1: 0,    s2: 0,    exp_peak: 2047, exp_last: 2047};
        rows[3] = '{n: 0, s0: 0,    s1: 0,    s2: 0,    exp_peak: 0,    exp_last: 2047};
        rows[4] = '{n: 2, s0: 1,    s1: 3000, s2: 0,    exp_peak: 2047, exp_last: 952};
        rows[5] = '{n: 0, s0: 0,    s1: 0,    s2: 0,    exp_peak: 0,    exp_last: 952};

        step(1'b1, 1'b0, 2048);
        step(1'b1, 1'b1, 4095);
        chk("rst_horz", int'(s_horz), S_HT - 1);
        chk("rst_sample", int'(s_sample), 0);

        // Table: one frame per row, result expected at the following frame start.
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < F_S; k++) begin
                logic v;
                int d;
                v = 1'b0;
                d = 2048;
                if (k == 50 && rows[r].n > 0) begin v = 1'b1; d = rows[r].s0; end
                if (k == 120 && rows[r].n > 1) begin v = 1'b1; d = rows[r].s1; end
                if (k == 300 && rows[r].n > 2) begin v = 1'b1; d = rows[r].s2; end
                step(1'b0, v, d);
                if (k == 0 && r == 0) begin
                    chk("first_horz", int'(s_horz), 0);
                    chk("first_vert", int'(s_vert), 0);
                    chk("first_active", int'(s_active), 1);
                    chk("first_fs", int'(s_fs), 1);
                    chk("first_sample", int'(s_sample), 0);
                end
                if (k == 0 && r > 0) begin
                    chk("tbl_fs", int'(s_fs), 1);
                    chk("tbl_sample", int'(s_sample), row_exp(rows[r - 1]));
                end
            end
        end

        // Sample on the boundary edge belongs to the new frame.
        step(1'b0, 1'b1, 4095);
        chk("bnd_fs", int'(s_fs), 1);
        chk("bnd_pub", int'(s_sample), row_exp(rows[5]));
        for (int k = 1; k < F_S; k++) step(1'b0, 1'b0, 2048);
        step(1'b0, 1'b0, 2048);
        chk("bnd_next", int'(s_sample), 2047);

        // Randomized frames, compared every cycle with the model.
        for (int k = 0; k < 5 * F_S; k++) begin
            step(1'b0, ($urandom_range(0, 15) == 0), int'($urandom_range(1, 4095)));
        end

        // Mid-frame reset at vert 5 after a loud sample.
        for (int i = 0; i < F_S && s_vert != 12'd5; i++) step(1'b0, 1'b0, 2048);
        chk("reach_vert5", int'(s_vert), 5);
        step(1'b0, 1'b1, 4095);
        step(1'b1, 1'b0, 2048);
        chk("mid_rst_horz", int'(s_horz), S_HT - 1);
        chk("mid_rst_vert", int'(s_vert), S_VT - 1);
        chk("mid_rst_fs", int'(s_fs), 0);
        fs_count = 0;
        step(1'b0, 1'b0, 2048);
        fs_count += int'(s_fs);
        chk("restart_horz", int'(s_horz), 0);
        chk("restart_vert", int'(s_vert), 0);
        chk("restart_active", int'(s_active), 1);
        chk("restart_sample", int'(s_sample), 0);
        for (int k = 1; k <= F_S; k++) begin
            step(1'b0, 1'b0, 2048);
            fs_count += int'(s_fs);
        end
        chk("restart_pub", int'(s_sample), 0);
        chk("fs_count", fs_count, 2);

        // Full-size line wrap at 1688 cycles after release.
        for (int i = 0; i < 2000 && t < 1688; i++) step(1'b0, 1'b0, 2048);
        chk("full_wrap_horz", int'(f_horz), 0);
        chk("full_wrap_vert", int'(f_vert), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
